// File: rtl/axis_frame_receiver.sv
// axis_frame_receiver: AXI4-Stream sink that writes one LENGTH-word frame into a RAM write port
// and reports framing errors. Optional tkeep check is enabled by defining AXIS_RX_KEEP_CHECK_EN.
module axis_frame_receiver #(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   Start,
    input  logic [31:0]            s_axis_tdata,
    input  logic [3:0]             s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   WrFull,
    output logic [DATA_SIZE-1:0]   WrData,
    output logic [LENGTH_SIZE-1:0] WrAdd,
    output logic                   WrEn,
    output logic                   Busy,
    output logic                   Done,
    output logic                   EarlyLast,
    output logic                   MissingLast,
`ifdef AXIS_RX_KEEP_CHECK_EN
    output logic                   KeepErr,
`endif
    output logic [15:0]            FrameCount
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t                 state;
    logic [LENGTH_SIZE-1:0] cnt;
    logic                   accept;
    logic                   last_word;

    // Bits of the stream that carry no information for this sink.
`ifdef AXIS_RX_KEEP_CHECK_EN
    logic unused_bits;
    assign unused_bits = ^s_axis_tdata[31:DATA_SIZE];
`else
    logic unused_bits;
    assign unused_bits = ^{s_axis_tdata[31:DATA_SIZE], s_axis_tkeep};
`endif

    // Ready follows the RAM in RECV so backpressure reaches the source in the same cycle;
    // DRAIN always accepts because those beats are discarded anyway.
    assign s_axis_tready = (state == RECV && !WrFull) || state == DRAIN;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign last_word     = cnt == LENGTH_SIZE'(LENGTH - 1);
    assign Busy          = state == RECV || state == DRAIN;

    // Frame FSM with registered write port, completion pulse and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            WrData      <= '0;
            WrAdd       <= '0;
            WrEn        <= 1'b0;
            Done        <= 1'b0;
            EarlyLast   <= 1'b0;
            MissingLast <= 1'b0;
            FrameCount  <= '0;
`ifdef AXIS_RX_KEEP_CHECK_EN
            KeepErr     <= 1'b0;
`endif
        end else begin
            WrEn <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state       <= RECV;
                        cnt         <= '0;
                        EarlyLast   <= 1'b0;
                        MissingLast <= 1'b0;
`ifdef AXIS_RX_KEEP_CHECK_EN
                        KeepErr     <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (accept) begin
                        WrEn   <= 1'b1;
                        WrData <= s_axis_tdata[DATA_SIZE-1:0];
                        WrAdd  <= cnt;
                        cnt    <= cnt + 1'b1;
`ifdef AXIS_RX_KEEP_CHECK_EN
                        if (s_axis_tkeep != 4'hF) KeepErr <= 1'b1;
`endif
                        if (s_axis_tlast) begin
                            EarlyLast  <= !last_word;
                            Done       <= 1'b1;
                            FrameCount <= FrameCount + 16'd1;
                            state      <= DONE;
                        end else if (last_word) begin
                            MissingLast <= 1'b1;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_axis_tlast) begin
                        Done       <= 1'b1;
                        FrameCount <= FrameCount + 16'd1;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_receiver.sv
// tb_axis_frame_receiver: randomized frames against a beat-level reference of the receiver.
module tb_axis_frame_receiver;

    localparam int DS  = 4;
    localparam int LEN = 256;
    localparam int LS  = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          Start = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = 4'hF;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          WrFull = 1'b0;
    logic [DS-1:0] WrData;
    logic [LS-1:0] WrAdd;
    logic          WrEn;
    logic          Busy;
    logic          Done;
    logic          EarlyLast;
    logic          MissingLast;
    logic [15:0]   FrameCount;
`ifdef AXIS_RX_KEEP_CHECK_EN
    logic          KeepErr;
`endif

    axis_frame_receiver #(.DATA_SIZE(DS), .LENGTH(LEN), .LENGTH_SIZE(LS)) dut (
        .clk(clk), .rstn(rstn), .Start(Start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .WrFull(WrFull),
        .WrData(WrData), .WrAdd(WrAdd), .WrEn(WrEn), .Busy(Busy), .Done(Done),
        .EarlyLast(EarlyLast), .MissingLast(MissingLast),
`ifdef AXIS_RX_KEEP_CHECK_EN
        .KeepErr(KeepErr),
`endif
        .FrameCount(FrameCount)
    );

    always #5 clk = ~clk;

    typedef struct {int c; int a; int d;} wr_t;
    wr_t exp_q[$];
    int  n_asrt = 0, n_fail = 0, cyc = 0, exp_done_cyc = -1, done_seen = 0, fc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asrt++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Every write must match the oldest expected write, one cycle after its beat was accepted.
    always @(negedge clk) begin
        if (rstn) begin
            if (WrEn) begin
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.c);
                    chk("wr_addr", WrAdd, e.a);
                    chk("wr_data", WrData, e.d);
                end
            end
            if (Done) begin
                done_seen++;
                chk("done_cycle", cyc, exp_done_cyc);
            end
        end
    end

    task automatic run_frame(input int nb, input bit bp, input bit gap, input bit nominal,
                             input int bad_keep, input int rst_at);
        int          k = 0, guard = 0, nrecv, d0;
        logic [31:0] dat;
        logic        exp_rdy;
        nrecv = nb < LEN ? nb : LEN;
        d0 = done_seen;
        @(posedge clk); #1;
        Start = 1'b1; s_axis_tvalid = 1'b0; WrFull = 1'b0;
        @(posedge clk); #1;
        while (k < nb && guard < 4000) begin
            Start = k == nb / 2;
            WrFull = bp && (cyc % 5 < 3);
            s_axis_tvalid = !gap || $urandom_range(0, 3) != 0;
            dat = nominal ? 32'(k) : $urandom();
            s_axis_tdata = dat;
            s_axis_tlast = k == nb - 1;
            s_axis_tkeep = k == bad_keep ? 4'h3 : 4'hF;
            @(negedge clk);
            if (guard == 0) begin
                chk("start_clr_early", EarlyLast, 0);
                chk("start_clr_missing", MissingLast, 0);
`ifdef AXIS_RX_KEEP_CHECK_EN
                chk("start_clr_keep", KeepErr, 0);
`endif
            end
            exp_rdy = k < nrecv ? !WrFull : 1'b1;
            chk("tready", s_axis_tready, exp_rdy);
            chk("busy", Busy, 1);
            if (s_axis_tvalid && s_axis_tready) begin
                if (k < nrecv) exp_q.push_back('{c: cyc + 1, a: k, d: int'(dat[DS-1:0])});
                if (k == nb - 1) exp_done_cyc = cyc + 1;
                k++;
                if (k - 1 == rst_at) begin
                    @(posedge clk); #1;
                    s_axis_tvalid = 1'b0; Start = 1'b0;
                    @(negedge clk); #2;
                    rstn = 1'b0;
                    #1;
                    chk("rst_wren", WrEn, 0);
                    chk("rst_busy", Busy, 0);
                    chk("rst_done", Done, 0);
                    chk("rst_tready", s_axis_tready, 0);
                    chk("rst_fc", FrameCount, 0);
                    chk("rst_addr", WrAdd, 0);
                    chk("rst_pending", exp_q.size(), 0);
                    exp_q.delete();
                    fc = 0;
                    exp_done_cyc = -1;
                    @(posedge clk); #1;
                    rstn = 1'b1;
                    return;
                end
            end
            guard++;
            @(posedge clk); #1;
        end
        chk("frame_timeout", k, nb);
        @(posedge clk); #1;
        Start = 1'b0; WrFull = 1'b0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_tready", s_axis_tready, 0);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        fc++;
        chk("done_count", done_seen - d0, 1);
        chk("frame_count", FrameCount, fc);
        chk("early_last", EarlyLast, nb < LEN);
        chk("missing_last", MissingLast, nb > LEN);
        chk("busy_idle", Busy, 0);
        chk("wr_pending", exp_q.size(), 0);
`ifdef AXIS_RX_KEEP_CHECK_EN
        chk("keep_err", KeepErr, bad_keep >= 0 && bad_keep < nrecv);
`endif
    endtask

    initial begin
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wren", WrEn, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_fc", FrameCount, 0);
        chk("reset_flags", {EarlyLast, MissingLast}, 0);
        chk("reset_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("nostart_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        run_frame(256, 1'b0, 1'b0, 1'b1, -1, -1);
        run_frame(256, 1'b1, 1'b1, 1'b0, -1, -1);
        run_frame(100, 1'b0, 1'b1, 1'b0, -1, -1);
        run_frame(300, 1'b1, 1'b1, 1'b0, -1, -1);
        run_frame(256, 1'b0, 1'b0, 1'b0, -1, 50);
        run_frame(256, 1'b0, 1'b0, 1'b1, -1, -1);
        run_frame(256, 1'b0, 1'b1, 1'b0, 10, -1);
        run_frame(256, 1'b1, 1'b0, 1'b0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_receiver.md
Name: axis_frame_receiver

Overview:
- AXI4-Stream sink, the receive-side counterpart of the S2MM frame source: consumes one frame of LENGTH words from the PS MM2S DMA channel.
- Unpacks the low DATA_SIZE bits of each beat and writes them sequentially into a local frame RAM write port (data/address/enable).
- Checks tlast framing and reports completion and errors to the register block.
- Sits between the block-design MM2S stream port and the frame buffer, in the clk200 domain.

Parameters:
- DATA_SIZE, 12, sample width taken from tdata[DATA_SIZE-1:0].
- LENGTH, 32768, words per frame; tlast is expected on word LENGTH-1.
- LENGTH_SIZE, 15, width of the write address; must satisfy 2**LENGTH_SIZE >= LENGTH.

Ports:
- clk  in  1  block clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- Start  in  1  one-cycle pulse that arms reception of one frame.
- s_axis_tdata  in  32  stream data; bits [31:DATA_SIZE] are ignored.
- s_axis_tkeep  in  4  byte qualifiers; only used by the optional feature.
- s_axis_tlast  in  1  end-of-frame marker.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  sink ready.
- WrFull  in  1  frame RAM cannot accept a write; applies backpressure.
- WrData  out  DATA_SIZE  RAM write data.
- WrAdd  out  LENGTH_SIZE  RAM write address.
- WrEn  out  1  RAM write strobe.
- Busy  out  1  high in RECV or DRAIN.
- Done  out  1  one-cycle pulse when a frame completes.
- EarlyLast  out  1  sticky flag: tlast arrived before word LENGTH-1.
- MissingLast  out  1  sticky flag: no tlast on word LENGTH-1.
- FrameCount  out  16  number of completed frames; wraps at 16'hFFFF->0.

Behaviour:
- Reset values: every output and internal register is 0; state is IDLE.
- Beat accepted when s_axis_tvalid && s_axis_tready.
- States:
  - IDLE: tready=0. Start -> RECV; word counter cleared to 0; EarlyLast and MissingLast cleared.
  - RECV: tready = !WrFull. On each accepted beat, the next cycle has WrEn=1, WrData=tdata[DATA_SIZE-1:0], WrAdd=counter value at acceptance. Write latency is exactly 1 cycle. Counter increments per accepted beat.
    - tlast with counter==LENGTH-1 -> DONE, no error.
    - tlast with counter<LENGTH-1 -> set EarlyLast, -> DONE. This beat is still written.
    - counter==LENGTH-1 without tlast -> set MissingLast, -> DRAIN. This beat is still written.
  - DRAIN: tready=1 regardless of WrFull. Beats are discarded (WrEn stays 0) up to and including the next tlast beat, then -> DONE.
  - DONE: one cycle. Done=1, FrameCount+1, -> IDLE.
- Start outside IDLE is ignored; flags are not cleared.
- tvalid with no Start: tready stays 0 and the beat is held by the source.
- WrFull rising in RECV: tready drops in the same cycle (combinational). Any write already registered still issues.
- WrEn is never asserted in IDLE, DRAIN or DONE, except for the single trailing write of the last RECV beat.
- Busy = (state==RECV || state==DRAIN).
- Error flags hold until the next accepted Start or reset.
- rstn asserted mid-frame: immediate return to IDLE with all outputs 0. The partial frame is abandoned and FrameCount is not incremented.

Optional Feature:
- Macro AXIS_RX_KEEP_CHECK_EN.
- Defined: adds output KeepErr (1 bit, sticky, cleared on accepted Start, reset 0). It is set when an accepted beat in RECV has s_axis_tkeep != 4'hF. That beat is still written normally.
- Not defined: the KeepErr port does not exist and tkeep is ignored.

Test Plan:
- Bench uses DATA_SIZE=4, LENGTH=256, LENGTH_SIZE=8.
- Nominal frame: Start, 256 beats tdata=i, tlast on beat 255, tvalid continuous -> WrEn 256 times, WrAdd 0..255, WrData=i[3:0], one cycle after each accept; Done pulse once; FrameCount=1; both error flags 0.
- Backpressure: WrFull toggled on a 3-on/2-off pattern and tvalid randomly gapped -> tready==!WrFull in RECV; no lost or duplicated writes; addresses contiguous 0..255; Done once.
- Early last: tlast on beat 99 -> 100 writes (addr 0..99), EarlyLast=1, Done pulse, back to IDLE with tready=0.
- Missing last: 300 beats with tlast on beat 299 -> 256 writes, MissingLast=1, beats 256..299 accepted without WrEn, Done after beat 299.
- Reset mid-frame: rstn low after beat 50, then Start and a nominal frame -> first post-reset write at WrAdd=0, FrameCount=1, flags 0.
- With AXIS_RX_KEEP_CHECK_EN defined: beat 10 with tkeep=4'h3 -> KeepErr=1 stays set; the next Start clears it to 0.
